// File: rtl/memory_b_port_arbiter_if.sv
// Requester-side bus of the memory port-B arbiter.
// Carries both requesters' request/address/grant signals and the shared read
// return path (per-requester valid strobes, shared data, error qualifier).
//   master : requester side (drives req/addr, sees gnt/rvalid/rdata/rerr)
//   slave  : arbiter side
// Handshake: a request is taken in any cycle where reqN and gntN are both high.
// addrN must be stable while reqN is high. gntN is combinational. Read data
// returns on rvalidN; rerr qualifies that strobe. No backpressure exists on the
// return path: the requester must accept rvalidN whenever it is high.
interface memory_b_port_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              rerr;

  modport master (
    output req0, addr0, req1, addr1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rerr
  );

  modport slave (
    input  req0, addr0, req1, addr1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rerr
  );
endinterface

// File: rtl/memory_b_port_arbiter.sv
// Arbiter for the read-only port B of the memory stage.
// Shares port B between the display scanout (requester 0, fixed priority) and
// the debug/host read path (requester 1, protected against starvation by a
// wait counter). The granted address is registered toward the memory, and a
// tag pipeline whose depth matches the memory's read latency tracks each
// in-flight read so the data returns with the right requester's strobe.
// Addresses inside the hole or beyond the mapped space are flagged on rerr.
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   bus        requester bus (slave modport), see memory_b_port_arbiter_if
//   mem_addr   registered address to memory port B
//   mem_rdata  memory port B read data
module memory_b_port_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 24,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 8,
  parameter int HOLE_LO      = 90000,
  parameter int HOLE_HI      = 90299,
  parameter int ADDR_LIMIT   = 180300
) (
  input  logic                   clk,
  input  logic                   rst,
  memory_b_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [ADDR_W-1:0] HOLE_LO_A    = ADDR_W'(HOLE_LO);
  localparam logic [ADDR_W-1:0] HOLE_HI_A    = ADDR_W'(HOLE_HI);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT_A = ADDR_W'(ADDR_LIMIT);
  localparam logic [7:0]        MAX_WAIT_C   = 8'(MAX_WAIT);

  // One entry per in-flight read. Stage 0 is loaded at the grant edge; the
  // last stage lines up with mem_rdata for that read.
  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } tag_t;

  tag_t [READ_LATENCY:0] tag_q, tag_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;

  logic              force1;
  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_err;
  tag_t              tag_out;

  always_comb begin
    // Requester 1 wins a contended cycle only once it has waited MAX_WAIT
    // cycles in a row. Grants are suppressed while reset is asserted.
    force1   = (wait_cnt_q == MAX_WAIT_C);
    gnt0     = rst & bus.req0 & ~(bus.req1 & force1);
    gnt1     = rst & bus.req1 & (~bus.req0 | force1);
    any_gnt  = gnt0 | gnt1;
    gnt_addr = gnt1 ? bus.addr1 : bus.addr0;
    gnt_err  = ((gnt_addr >= HOLE_LO_A) && (gnt_addr <= HOLE_HI_A)) ||
               (gnt_addr >= ADDR_LIMIT_A);

    // Counts consecutive denied cycles; any break (grant or dropped request)
    // restarts the count. Saturates rather than wrapping.
    wait_cnt_d = wait_cnt_q;
    if (!bus.req1 || gnt1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    mem_addr_d = any_gnt ? gnt_addr : mem_addr_q;

    tag_d          = '0;
    tag_d[0].valid = any_gnt;
    tag_d[0].id    = gnt1;
    tag_d[0].err   = any_gnt & gnt_err;
    for (int i = 1; i <= READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Reset empties the tag pipeline, so reads in flight at reset are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q      <= '0;
      wait_cnt_q <= '0;
      mem_addr_q <= '0;
    end else begin
      tag_q      <= tag_d;
      wait_cnt_q <= wait_cnt_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign tag_out = tag_q[READ_LATENCY];

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = tag_out.valid & ~tag_out.id;
  assign bus.rvalid1 = tag_out.valid &  tag_out.id;
  assign bus.rerr    = tag_out.valid &  tag_out.err;
  // Error reads still come back in their slot but never expose memory data.
  assign bus.rdata   = (tag_out.valid && !tag_out.err) ? mem_rdata : '0;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_memory_b_port_arbiter.sv
module tb_memory_b_port_arbiter;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 24;
  localparam int RL         = 2;
  localparam int MAX_WAIT   = 8;
  localparam int HOLE_LO    = 90000;
  localparam int HOLE_HI    = 90299;
  localparam int ADDR_LIMIT = 180300;
  // expected response: {due cycle[31:0], id, err, data[23:0]}
  localparam int RSP_W      = 32 + 2 + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] m_s1 = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  memory_b_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_b_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .MAX_WAIT(MAX_WAIT),
    .HOLE_LO(HOLE_LO), .HOLE_HI(HOLE_HI), .ADDR_LIMIT(ADDR_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model (address FF + output FF) ----------------
  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    if (a == 18'd100) return 24'hABCDEF;
    return {6'h15, a};
  endfunction

  always @(posedge clk) begin
    m_s1      <= mem_addr;
    mem_rdata <= mem_f(m_s1);
  end

  function automatic bit err_f(input int a);
    return ((a >= HOLE_LO) && (a <= HOLE_HI)) || (a >= ADDR_LIMIT);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / behavioural model ----------------
  logic [RSP_W-1:0]  exp_q[$];
  int                wait_m = 0;
  logic [ADDR_W-1:0] mem_addr_m = '0;

  always @(negedge clk) begin
    logic eg0, eg1, ev0, ev1, eerr, e_err;
    logic [DATA_W-1:0] ed;
    logic [RSP_W-1:0]  e;
    if (!rst) begin
      chk("rst_gnt0", 64'(bus.gnt0), 64'(0));
      chk("rst_gnt1", 64'(bus.gnt1), 64'(0));
      chk("rst_rvalid0", 64'(bus.rvalid0), 64'(0));
      chk("rst_rvalid1", 64'(bus.rvalid1), 64'(0));
      chk("rst_rerr", 64'(bus.rerr), 64'(0));
      chk("rst_rdata", 64'(bus.rdata), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      exp_q.delete();
      wait_m     = 0;
      mem_addr_m = '0;
    end else begin
      eg0 = bus.req0 && !(bus.req1 && (wait_m == MAX_WAIT));
      eg1 = bus.req1 && !eg0;
      chk("gnt0", 64'(bus.gnt0), 64'(eg0));
      chk("gnt1", 64'(bus.gnt1), 64'(eg1));
      chk("mem_addr", 64'(mem_addr), 64'(mem_addr_m));
      chk("wait_cnt", 64'(dut.wait_cnt_q), 64'(wait_m));
      ev0 = 1'b0; ev1 = 1'b0; eerr = 1'b0; ed = '0;
      if (exp_q.size() != 0 && int'(exp_q[0][RSP_W-1 -: 32]) == cyc) begin
        e    = exp_q.pop_front();
        ev0  = !e[DATA_W+1];
        ev1  = e[DATA_W+1];
        eerr = e[DATA_W];
        ed   = e[DATA_W-1:0];
      end
      chk("rvalid0", 64'(bus.rvalid0), 64'(ev0));
      chk("rvalid1", 64'(bus.rvalid1), 64'(ev1));
      chk("rerr", 64'(bus.rerr), 64'(eerr));
      chk("rdata", 64'(bus.rdata), 64'(ed));
      if (eg0 || eg1) begin
        mem_addr_m = eg1 ? bus.addr1 : bus.addr0;
        e_err = err_f(int'(mem_addr_m));
        exp_q.push_back({32'(cyc + 1 + RL), eg1, e_err,
                         e_err ? {DATA_W{1'b0}} : mem_f(mem_addr_m)});
      end
      if (!bus.req1 || eg1) wait_m = 0;
      else if (wait_m < MAX_WAIT) wait_m = wait_m + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
  endtask

  task automatic single_read(input string tag);
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.req0  = (i == 0);
      bus.addr0 = 18'd100;
      bus.req1  = 1'b0;
      @(negedge clk);
      if (i == 0) chk({tag, "_gnt0"}, 64'(bus.gnt0), 64'(1));
      if (i == 1) chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(100));
      if (i == 2) chk({tag, "_early"}, 64'(bus.rvalid0), 64'(0));
      if (i == 3) begin
        chk({tag, "_rvalid0"}, 64'(bus.rvalid0), 64'(1));
        chk({tag, "_rdata"}, 64'(bus.rdata), 64'(24'hABCDEF));
        chk({tag, "_rerr"}, 64'(bus.rerr), 64'(0));
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  int            rv0_cnt;
  int            err_addr[5] = '{90000, 90299, 180300, 89999, 90300};
  logic          err_exp[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [23:0]   err_dat[5]  = '{24'h0, 24'h0, 24'h0, 24'h555F8F, 24'h5560BC};

  initial begin
    bus.req0 = 1'b1; bus.addr0 = 18'd5;
    bus.req1 = 1'b1; bus.addr1 = 18'd7;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt0_held_low", 64'(bus.gnt0), 64'(0));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    tick();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    idle(2);

    single_read("single");

    // contention: both held high, requester 1 forced every 9th cycle
    tick();
    bus.req0 = 1'b1; bus.addr0 = 18'd10;
    bus.req1 = 1'b1; bus.addr1 = 18'd20;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("contend_gnt1", 64'(bus.gnt1), 64'((i == 8) || (i == 17)));
      if (i == 8) chk("contend_wait_sat", 64'(dut.wait_cnt_q), 64'(8));
      if (i == 9) chk("contend_wait_clr", 64'(dut.wait_cnt_q), 64'(0));
      @(posedge clk);
      #1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    idle(5);

    // streaming 10 back-to-back reads of addresses 0..9
    rv0_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      bus.req0  = (i < 10);
      bus.addr0 = ADDR_W'(i);
      @(negedge clk);
      if (bus.rvalid0) rv0_cnt++;
      if (i == 3) chk("stream_first_data", 64'(bus.rdata), 64'(24'h540000));
    end
    chk("stream_count", 64'(rv0_cnt), 64'(10));

    // error region on requester 1
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.req0  = 1'b0;
      bus.req1  = (i < 5);
      bus.addr1 = (i < 5) ? ADDR_W'(err_addr[i]) : '0;
      @(negedge clk);
      if (i >= 3) begin
        chk("errreg_rvalid1", 64'(bus.rvalid1), 64'(1));
        chk("errreg_rerr", 64'(bus.rerr), 64'(err_exp[i-3]));
        chk("errreg_rdata", 64'(bus.rdata), 64'(err_dat[i-3]));
      end
    end
    idle(3);

    // mid-flight reset discards the read granted just before it
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.req0  = (i == 0);
      bus.addr0 = 18'd200;
      if (i == 1) rst = 1'b0;
      if (i == 2) rst = 1'b1;
      @(negedge clk);
      if (i == 1) chk("midrst_mem_addr", 64'(mem_addr), 64'(0));
      if (i == 3) chk("midrst_no_rvalid", 64'(bus.rvalid0), 64'(0));
    end
    single_read("post_rst");

    // ordering: requester 1 then requester 0 on consecutive cycles
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.req1  = (i == 0);
      bus.addr1 = 18'd300;
      bus.req0  = (i == 1);
      bus.addr0 = 18'd400;
      @(negedge clk);
      if (i == 3) begin
        chk("order_rvalid1", 64'(bus.rvalid1), 64'(1));
        chk("order_rvalid0_low", 64'(bus.rvalid0), 64'(0));
      end
      if (i == 4) begin
        chk("order_rvalid0", 64'(bus.rvalid0), 64'(1));
        chk("order_rvalid1_low", 64'(bus.rvalid1), 64'(0));
        chk("order_rdata", 64'(bus.rdata), 64'(24'h540190));
      end
    end
    idle(4);
    @(negedge clk);
    chk("drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_b_port_arbiter.md
# memory_b_port_arbiter

Arbiter for the read-only port B of the memory stage (image ROM / data RAM second port). It shares that port between two requesters, the display scanout (requester 0, priority) and the debug/host read path (requester 1, starvation-protected). It registers the granted address toward the memory, tracks each in-flight read through a tag pipeline matched to the memory's registered latency, and returns data with a per-requester valid strobe. Addresses in the sine-ROM hole and beyond the mapped space are flagged as errors.

## Interface
Parameters:
- ADDR_W, 18, address width (matches memory stage address_b).
- DATA_W, 24, data width.
- READ_LATENCY, 2, cycles from mem_addr valid to mem_rdata valid (address FF + output FF); legal range 1..4.
- MAX_WAIT, 8, consecutive denied cycles of requester 1 before it is forced a grant; legal range 1..255.
- HOLE_LO, 90000, first address of the region not readable on port B.
- HOLE_HI, 90299, last address of that region.
- ADDR_LIMIT, 180300, first unmapped address.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  display read request; addr0 stable while high.
- addr0  in  ADDR_W  display read address.
- gnt0  out  1  combinational; request 0 accepted this cycle.
- rvalid0  out  1  read data for requester 0 valid this cycle.
- req1  in  1  debug read request.
- addr1  in  ADDR_W  debug read address.
- gnt1  out  1  combinational; request 1 accepted this cycle.
- rvalid1  out  1  read data for requester 1 valid this cycle.
- rdata  out  DATA_W  returned data (shared by both requesters).
- rerr  out  1  qualifies rvalid0/rvalid1: address was in hole or >= ADDR_LIMIT.
- mem_addr  out  ADDR_W  registered address to memory port B.
- mem_rdata  in  DATA_W  memory port B output.

## Operation
- Handshake: requester raises req with addr; request is taken in the cycle gnt is high (gnt = req AND arbiter choice). Requester may present next request in the following cycle; one grant total per cycle, so throughput is 1 read/cycle.
- Arbitration: only req0 -> gnt0; only req1 -> gnt1; both -> gnt0 unless wait_cnt == MAX_WAIT, then gnt1.
- wait_cnt (8-bit): increments each cycle req1=1 and gnt1=0, saturating at MAX_WAIT; clears to 0 on gnt1 or when req1=0.
- On any grant: mem_addr <= granted addr at that edge; with no grant mem_addr holds.
- Tag pipeline, READ_LATENCY+1 stages, each {valid, id, err}; stage 0 loaded on grant (err = addr in [HOLE_LO,HOLE_HI] or addr >= ADDR_LIMIT), else valid=0. Final stage drives rvalid0 (valid AND id=0), rvalid1 (valid AND id=1), rerr (valid AND err).
- rdata = mem_rdata when final stage valid and not err; 0 otherwise.
- Error reads still consume a grant slot and return after the normal latency.

## Timing
- Grant in cycle T -> mem_addr valid T+1 -> rvalid/rdata in cycle T+1+READ_LATENCY (T+3 at default). Responses return strictly in grant order.
- Back-to-back grants T, T+1 -> responses T+3, T+4.
- Reset (rst=0, any time): mem_addr=0, wait_cnt=0, all tag stages invalid; rvalid0=rvalid1=rerr=0, rdata=0; gnt0=gnt1=0 while rst=0. In-flight reads are discarded, never delivered after reset release.
- First grant possible in the first cycle with rst=1.
- Boundaries: addr=HOLE_LO-1 and HOLE_HI+1 are valid; HOLE_LO, HOLE_HI, ADDR_LIMIT flagged. Counter saturates, never wraps.

## Test plan
- Single read: req0, addr0=100 at T, mem model returns 24'hABCDEF -> gnt0 at T, mem_addr=100 at T+1, rvalid0=1, rdata=ABCDEF, rerr=0 at T+3.
- Contention: req0 and req1 held high continuously, MAX_WAIT=8 -> gnt0 for 8 cycles, gnt1 on 9th, wait_cnt back to 0; pattern repeats every 9 cycles.
- Streaming: req0 high 10 cycles, addr 0..9 -> rvalid0 on 10 consecutive cycles, data in address order.
- Error region: req1 with addr1=90000, 90299, 180300, then 89999, 90300 -> rvalid1 with rerr=1, rdata=0 for first three; rerr=0, memory data for last two.
- Mid-flight reset: grant at T, rst=0 at T+1 for one cycle -> no rvalid at T+3, mem_addr=0, next grant after release behaves normally.
- Ordering: gnt1 at T, gnt0 at T+1 -> rvalid1 at T+3, rvalid0 at T+4, never both high in one cycle.
